vote_tally: RTL and testbench
=============================

VOTE_TALLY -- requirements
Module: vote_tally

Interface
REQ-001 SHALL have parameter NUM_CAND, default 4, number of candidate channels (2..16).
REQ-002 SHALL have parameter CNT_W, default 8, width of each per-candidate counter (2..16).
REQ-003 SHALL have parameter IDX_W, default $clog2(NUM_CAND), width of candidate index outputs.
REQ-004 SHALL have port clock  input  1  sole clock, all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port mode  input  1  0 = voting open, 1 = voting closed/result display.
REQ-007 SHALL have port vote_valid  input  NUM_CAND  per-candidate vote request, bit i = candidate i.
REQ-008 SHALL have port vote_count  output  NUM_CAND*CNT_W  flat counter bus, candidate i at bits [i*CNT_W +: CNT_W].
REQ-009 SHALL have port vote_accepted  output  1  one-cycle pulse when a vote is counted.
REQ-010 SHALL have port accepted_idx  output  IDX_W  index of candidate counted, valid with vote_accepted.
REQ-011 SHALL have port total_votes  output  CNT_W+IDX_W  sum of all accepted votes.
REQ-012 SHALL have port winner_idx  output  IDX_W  index of leading candidate.
REQ-013 SHALL have port tie  output  1  high when two or more candidates share the maximum count.
REQ-014 SHALL have port saturated  output  1  sticky flag, a vote was discarded because its counter was at max.

Function
REQ-015 FSM states SHALL be READY (accepting) and LOCKED (awaiting release).
REQ-016 In READY with mode=0 and vote_valid!=0, SHALL accept exactly one vote for the lowest set index, then go to LOCKED.
REQ-017 In LOCKED SHALL ignore all vote_valid; SHALL return to READY on the first cycle vote_valid==0.
REQ-018 Holding a request for many cycles SHALL count one vote only; a new vote requires release then press.
REQ-019 With mode=1 SHALL accept no votes; FSM SHALL still track release (LOCKED->READY on vote_valid==0; READY stays READY).
REQ-020 Accepted vote SHALL appear in vote_count and total_votes on the cycle after the sampling edge (1-cycle latency).
REQ-021 vote_accepted and accepted_idx SHALL assert in that same cycle for one cycle; accepted_idx SHALL be 0 when vote_accepted=0.
REQ-022 Counter at 2^CNT_W-1 SHALL hold; vote SHALL be consumed (FSM to LOCKED), vote_accepted SHALL stay 0, total_votes SHALL not change, saturated SHALL set.
REQ-023 total_votes SHALL never wrap, width guarantees NUM_CAND*(2^CNT_W-1) fits.
REQ-024 winner_idx and tie SHALL be registered from current counts, reflecting vote_count with one further cycle of latency.
REQ-025 winner_idx SHALL be lowest index holding the maximum count; all-zero counts give winner_idx=0, tie=1.
REQ-026 Outputs SHALL be valid in both modes; mode change SHALL not alter counts.

Reset
REQ-027 reset SHALL dominate all inputs in the cycle it is sampled high.
REQ-028 On reset: all counters 0, total_votes 0, vote_accepted 0, accepted_idx 0, saturated 0, winner_idx 0, tie 1, FSM READY.
REQ-029 Reset mid-press: after release of reset with vote_valid still high, SHALL count that press once (FSM starts READY).

Structure
REQ-030 Package vote_pkg SHALL hold FSM state enum and mode encodings (MODE_VOTE=0, MODE_RESULT=1).
REQ-031 Per-candidate saturating counter SHALL be sub-module vote_sat_counter (params CNT_W; inputs clock, reset, inc; outputs count, at_max).
REQ-032 Lowest-index priority select and max/tie compare SHALL be parametrised loops in vote_tally, no per-candidate hand coding.

Verification
REQ-033 Defaults; after reset pulse vote_valid=4'b0010 for 1 cycle -> next cycle vote_count cand1=1, vote_accepted=1, accepted_idx=1, total_votes=1.
REQ-034 Hold vote_valid=4'b0001 for 10 cycles, release, press again -> cand0=2, two vote_accepted pulses only.
REQ-035 vote_valid=4'b1100 one cycle -> cand2=1, cand3=0; winner_idx=2, tie=0 two cycles after sample.
REQ-036 mode=1, press cand3 -> no count change, no pulse; mode=0 while still held -> no count until release and re-press.
REQ-037 CNT_W=2: press cand0 four times -> cand0=3, total_votes=3, 4th press no pulse, saturated=1 until reset.
REQ-038 Counts cand0=2, cand1=2 -> winner_idx=0, tie=1; reset asserted with cand2 held -> all zero, then cand2=1 one cycle after reset deasserts.

Source files
------------

// File: rtl/vote_pkg.sv
// Shared types for the vote tally: FSM state encoding and mode encodings.
package vote_pkg;

    typedef enum logic {
        ST_READY  = 1'b0,
        ST_LOCKED = 1'b1
    } vote_state_e;

    localparam logic MODE_VOTE   = 1'b0;
    localparam logic MODE_RESULT = 1'b1;

endpackage : vote_pkg

// File: rtl/vote_tally_if.sv
// Vote tally bus: mode/vote requests in, counts and result flags out.
//   mode          - 0 voting open, 1 voting closed
//   vote_valid    - per-candidate vote request
//   vote_count    - flat counter bus, candidate i at [i*CNT_W +: CNT_W]
//   vote_accepted - one-cycle pulse per counted vote, accepted_idx alongside
//   total_votes   - sum of accepted votes
//   winner_idx    - lowest index holding the maximum count, tie when shared
//   saturated     - sticky, a vote hit a full counter
interface vote_tally_if #(
    parameter int unsigned NUM_CAND = 4,
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned IDX_W    = $clog2(NUM_CAND)
);
    logic                        mode;
    logic [NUM_CAND-1:0]         vote_valid;
    logic [NUM_CAND*CNT_W-1:0]   vote_count;
    logic                        vote_accepted;
    logic [IDX_W-1:0]            accepted_idx;
    logic [CNT_W+IDX_W-1:0]      total_votes;
    logic [IDX_W-1:0]            winner_idx;
    logic                        tie;
    logic                        saturated;

    modport master (
        output mode, vote_valid,
        input  vote_count, vote_accepted, accepted_idx, total_votes,
               winner_idx, tie, saturated
    );

    modport slave (
        input  mode, vote_valid,
        output vote_count, vote_accepted, accepted_idx, total_votes,
               winner_idx, tie, saturated
    );
endinterface : vote_tally_if

// File: rtl/vote_sat_counter.sv
// Per-candidate saturating counter.
//   clock, reset - clock and synchronous active-high reset
//   inc          - count one vote (ignored when full)
//   count        - current count
//   at_max       - count is at 2^CNT_W-1
module vote_sat_counter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             at_max
);
    localparam logic [CNT_W-1:0] MAX_CNT = {CNT_W{1'b1}};

    // at_max is registered alongside count so it is ready the cycle count reaches max
    always_ff @(posedge clock) begin
        if (reset) begin
            count  <= '0;
            at_max <= 1'b0;
        end else if (inc && !at_max) begin
            count  <= count + CNT_W'(1);
            at_max <= (count == (MAX_CNT - CNT_W'(1)));
        end
    end
endmodule : vote_sat_counter

// File: rtl/vote_tally.sv
// Vote tally: one vote per press, lowest requesting index wins the slot,
// saturating per-candidate counters, running total and registered leader/tie.
//   clock, reset - clock and synchronous active-high reset
//   bus          - vote_tally_if slave (requests in, counts/results out)
module vote_tally
    import vote_pkg::*;
#(
    parameter int unsigned NUM_CAND = 4,
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned IDX_W    = $clog2(NUM_CAND)
) (
    input  logic         clock,
    input  logic         reset,
    vote_tally_if.slave  bus
);
    localparam int unsigned TOT_W = CNT_W + IDX_W;

    vote_state_e         state_q, state_d;
    logic [CNT_W-1:0]    cnt [NUM_CAND];
    logic [NUM_CAND-1:0] at_max;
    logic [NUM_CAND-1:0] inc_c;
    logic [IDX_W-1:0]    sel_idx_c;
    logic                any_c;
    logic                take_c;
    logic                count_c;
    logic                sat_hit_c;
    logic [CNT_W-1:0]    max_c;
    logic [IDX_W-1:0]    win_c;
    logic [IDX_W:0]      n_eq_c;
    logic                tie_c;

    // Lowest set request index
    always_comb begin
        sel_idx_c = '0;
        any_c     = |bus.vote_valid;
        for (int i = int'(NUM_CAND) - 1; i >= 0; i--) begin
            if (bus.vote_valid[i]) sel_idx_c = IDX_W'(i);
        end
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) state_q <= ST_READY;
        else       state_q <= state_d;
    end

    // Next state; a press always locks, even when closed, so it must be
    // released before it can count after voting reopens
    always_comb begin
        state_d = state_q;
        take_c  = 1'b0;
        case (state_q)
            ST_READY: begin
                if (any_c) begin
                    state_d = ST_LOCKED;
                    take_c  = (bus.mode == MODE_VOTE);
                end
            end
            ST_LOCKED: begin
                if (!any_c) state_d = ST_READY;
            end
            default: state_d = ST_READY;
        endcase
    end

    // A taken vote on a full counter is consumed but not counted
    always_comb begin
        count_c   = take_c && !at_max[sel_idx_c];
        sat_hit_c = take_c &&  at_max[sel_idx_c];
        inc_c     = '0;
        for (int i = 0; i < int'(NUM_CAND); i++) begin
            inc_c[i] = count_c && (sel_idx_c == IDX_W'(i));
        end
    end

    for (genvar g = 0; g < int'(NUM_CAND); g++) begin : g_cand
        vote_sat_counter #(.CNT_W(CNT_W)) u_cnt (
            .clock  (clock),
            .reset  (reset),
            .inc    (inc_c[g]),
            .count  (cnt[g]),
            .at_max (at_max[g])
        );
        assign bus.vote_count[g*CNT_W +: CNT_W] = cnt[g];
    end

    // Leader: strict '>' keeps the lowest index on equal counts
    always_comb begin
        max_c  = '0;
        win_c  = '0;
        n_eq_c = '0;
        for (int i = 0; i < int'(NUM_CAND); i++) begin
            if (cnt[i] > max_c) begin
                max_c = cnt[i];
                win_c = IDX_W'(i);
            end
        end
        for (int i = 0; i < int'(NUM_CAND); i++) begin
            if (cnt[i] == max_c) n_eq_c = n_eq_c + (IDX_W+1)'(1);
        end
        tie_c = (n_eq_c > (IDX_W+1)'(1));
    end

    // Registered result outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            bus.vote_accepted <= 1'b0;
            bus.accepted_idx  <= '0;
            bus.total_votes   <= '0;
            bus.saturated     <= 1'b0;
            bus.winner_idx    <= '0;
            bus.tie           <= 1'b1;
        end else begin
            bus.vote_accepted <= count_c;
            bus.accepted_idx  <= count_c ? sel_idx_c : '0;
            if (count_c)   bus.total_votes <= bus.total_votes + TOT_W'(1);
            if (sat_hit_c) bus.saturated   <= 1'b1;
            bus.winner_idx    <= win_c;
            bus.tie           <= tie_c;
        end
    end
endmodule : vote_tally

// File: tb/tb_vote_tally.sv
// Directed bench for vote_tally: default instance plus a CNT_W=2 instance
// for saturation.
module tb_vote_tally;
    logic clock = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    int   pulses;

    always #5 clock = ~clock;

    vote_tally_if #(.NUM_CAND(4), .CNT_W(8), .IDX_W(2)) a_if ();
    vote_tally_if #(.NUM_CAND(4), .CNT_W(2), .IDX_W(2)) b_if ();

    vote_tally #(.NUM_CAND(4), .CNT_W(8), .IDX_W(2)) dut_a (
        .clock (clock),
        .reset (rst_a),
        .bus   (a_if)
    );

    vote_tally #(.NUM_CAND(4), .CNT_W(2), .IDX_W(2)) dut_b (
        .clock (clock),
        .reset (rst_b),
        .bus   (b_if)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [7:0] cnt_a(input int i);
        return a_if.vote_count[i*8 +: 8];
    endfunction

    function automatic logic [1:0] cnt_b(input int i);
        return b_if.vote_count[i*2 +: 2];
    endfunction

    task automatic press_a(input logic [3:0] mask);
        a_if.vote_valid = mask;
        tick();
        a_if.vote_valid = 4'b0000;
        tick();
    endtask

    initial begin
        a_if.mode = 1'b0;  a_if.vote_valid = 4'b0000;
        b_if.mode = 1'b0;  b_if.vote_valid = 4'b0000;
        tick();
        tick();

        // Reset state
        check_eq("rst_counts", 32'(a_if.vote_count), 32'h0);
        check_eq("rst_total",  32'(a_if.total_votes), 32'd0);
        check_eq("rst_acc",    32'(a_if.vote_accepted), 32'd0);
        check_eq("rst_idx",    32'(a_if.accepted_idx), 32'd0);
        check_eq("rst_sat",    32'(a_if.saturated), 32'd0);
        check_eq("rst_win",    32'(a_if.winner_idx), 32'd0);
        check_eq("rst_tie",    32'(a_if.tie), 32'd1);
        rst_a = 1'b0;
        rst_b = 1'b0;

        // Single vote for candidate 1
        a_if.vote_valid = 4'b0010;
        tick();
        check_eq("v1_cnt1",  32'(cnt_a(1)), 32'd1);
        check_eq("v1_acc",   32'(a_if.vote_accepted), 32'd1);
        check_eq("v1_idx",   32'(a_if.accepted_idx), 32'd1);
        check_eq("v1_total", 32'(a_if.total_votes), 32'd1);
        a_if.vote_valid = 4'b0000;
        tick();
        check_eq("v1_acc_drop", 32'(a_if.vote_accepted), 32'd0);
        check_eq("v1_idx_drop", 32'(a_if.accepted_idx), 32'd0);
        check_eq("v1_win",      32'(a_if.winner_idx), 32'd1);
        check_eq("v1_tie",      32'(a_if.tie), 32'd0);

        // Long hold counts once; release + press counts again
        pulses = 0;
        a_if.vote_valid = 4'b0001;
        repeat (10) begin
            tick();
            pulses += int'(a_if.vote_accepted);
        end
        a_if.vote_valid = 4'b0000;
        tick();
        pulses += int'(a_if.vote_accepted);
        a_if.vote_valid = 4'b0001;
        tick();
        pulses += int'(a_if.vote_accepted);
        a_if.vote_valid = 4'b0000;
        tick();
        pulses += int'(a_if.vote_accepted);
        check_eq("hold_pulses", 32'(pulses), 32'd2);
        check_eq("hold_cnt0",   32'(cnt_a(0)), 32'd2);
        check_eq("hold_total",  32'(a_if.total_votes), 32'd3);
        tick();
        check_eq("hold_win", 32'(a_if.winner_idx), 32'd0);
        check_eq("hold_tie", 32'(a_if.tie), 32'd0);

        // Two requests at once: lowest index wins
        rst_a = 1'b1;
        tick();
        rst_a = 1'b0;
        a_if.vote_valid = 4'b1100;
        tick();
        check_eq("pri_cnt2", 32'(cnt_a(2)), 32'd1);
        check_eq("pri_cnt3", 32'(cnt_a(3)), 32'd0);
        check_eq("pri_idx",  32'(a_if.accepted_idx), 32'd2);
        a_if.vote_valid = 4'b0000;
        tick();
        check_eq("pri_win", 32'(a_if.winner_idx), 32'd2);
        check_eq("pri_tie", 32'(a_if.tie), 32'd0);

        // Closed mode, then reopen while still held
        a_if.mode = 1'b1;
        a_if.vote_valid = 4'b1000;
        tick();
        check_eq("closed_acc",  32'(a_if.vote_accepted), 32'd0);
        check_eq("closed_cnt3", 32'(cnt_a(3)), 32'd0);
        tick();
        a_if.mode = 1'b0;
        tick();
        tick();
        check_eq("reopen_acc",   32'(a_if.vote_accepted), 32'd0);
        check_eq("reopen_cnt3",  32'(cnt_a(3)), 32'd0);
        check_eq("reopen_total", 32'(a_if.total_votes), 32'd1);
        a_if.vote_valid = 4'b0000;
        tick();
        a_if.vote_valid = 4'b1000;
        tick();
        check_eq("repress_acc",   32'(a_if.vote_accepted), 32'd1);
        check_eq("repress_idx",   32'(a_if.accepted_idx), 32'd3);
        check_eq("repress_cnt3",  32'(cnt_a(3)), 32'd1);
        check_eq("repress_total", 32'(a_if.total_votes), 32'd2);
        a_if.vote_valid = 4'b0000;
        tick();

        // Tie between 0 and 1, then reset with candidate 2 held
        rst_a = 1'b1;
        tick();
        rst_a = 1'b0;
        press_a(4'b0001);
        press_a(4'b0010);
        press_a(4'b0001);
        press_a(4'b0010);
        tick();
        check_eq("tie_win",   32'(a_if.winner_idx), 32'd0);
        check_eq("tie_tie",   32'(a_if.tie), 32'd1);
        check_eq("tie_total", 32'(a_if.total_votes), 32'd4);
        a_if.vote_valid = 4'b0100;
        rst_a = 1'b1;
        tick();
        check_eq("midrst_counts", 32'(a_if.vote_count), 32'h0);
        check_eq("midrst_total",  32'(a_if.total_votes), 32'd0);
        check_eq("midrst_acc",    32'(a_if.vote_accepted), 32'd0);
        check_eq("midrst_tie",    32'(a_if.tie), 32'd1);
        rst_a = 1'b0;
        tick();
        check_eq("postrst_cnt2",  32'(cnt_a(2)), 32'd1);
        check_eq("postrst_acc",   32'(a_if.vote_accepted), 32'd1);
        check_eq("postrst_idx",   32'(a_if.accepted_idx), 32'd2);
        check_eq("postrst_total", 32'(a_if.total_votes), 32'd1);
        a_if.vote_valid = 4'b0000;
        tick();

        // Saturation on the 2-bit instance
        for (int k = 0; k < 4; k++) begin
            b_if.vote_valid = 4'b0001;
            tick();
            check_eq($sformatf("sat_press%0d_acc", k), 32'(b_if.vote_accepted),
                     (k < 3) ? 32'd1 : 32'd0);
            if (k == 2) check_eq("sat_before", 32'(b_if.saturated), 32'd0);
            b_if.vote_valid = 4'b0000;
            tick();
        end
        check_eq("sat_cnt0",  32'(cnt_b(0)), 32'd3);
        check_eq("sat_total", 32'(b_if.total_votes), 32'd3);
        check_eq("sat_flag",  32'(b_if.saturated), 32'd1);
        b_if.vote_valid = 4'b0001;
        tick();
        b_if.vote_valid = 4'b0000;
        tick();
        check_eq("sat_sticky", 32'(b_if.saturated), 32'd1);
        check_eq("sat_hold",   32'(cnt_b(0)), 32'd3);
        rst_b = 1'b1;
        tick();
        check_eq("sat_clear", 32'(b_if.saturated), 32'd0);
        rst_b = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule : tb_vote_tally
